// File: rtl/abro_driver.sv
// abro_driver: drives A/B stimulus sequences into an ABRO responder, judges O.
// Define ABRO_DRV_TIMEOUT_EN to bound the WAIT_O phase by TIMEOUT cycles.
module abro_driver #(
  parameter int CW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] gap,
  output logic          A,
  output logic          B,
  input  logic          O,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err_timeout,
  output logic          err_early,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    GAP    = 3'd2,
    SECOND = 3'd3,
    WAIT_O = 3'd4,
    DONE   = 3'd5
  } st_t;

  localparam logic [1:0] M_AB  = 2'b00;
  localparam logic [1:0] M_BA  = 2'b01;
  localparam logic [1:0] M_SIM = 2'b10;
  localparam logic [1:0] M_NEG = 2'b11;

  if (TIMEOUT < 1 || TIMEOUT >= (2 ** CW)) begin : g_bad_timeout
    $error("abro_driver: TIMEOUT out of range");
  end

  st_t          st;
  logic [1:0]   mode_q;
  logic [CW-1:0] gcnt;

  assign state = st;

`ifdef ABRO_DRV_TIMEOUT_EN
  logic [CW-1:0] wcnt;
  logic          err_to_q;

  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      mode_q    <= 2'b00;
      gcnt      <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_early <= 1'b0;
`ifdef ABRO_DRV_TIMEOUT_EN
      wcnt      <= '0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      A    <= 1'b0;
      B    <= 1'b0;
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            st        <= FIRST;
            mode_q    <= mode;
            gcnt      <= gap;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_early <= 1'b0;
`ifdef ABRO_DRV_TIMEOUT_EN
            err_to_q  <= 1'b0;
`endif
            A <= (mode != M_BA);
            B <= (mode == M_BA) || (mode == M_SIM);
          end
        end
        FIRST: begin
          if (O) begin
            st        <= DONE;
            done      <= 1'b1;
            pass      <= 1'b0;
            err_early <= 1'b1;
          end else if (mode_q == M_SIM || mode_q == M_NEG) begin
            st <= WAIT_O;
`ifdef ABRO_DRV_TIMEOUT_EN
            wcnt <= '0;
`endif
          end else if (gcnt == '0) begin
            st <= SECOND;
            A  <= (mode_q == M_BA);
            B  <= (mode_q == M_AB);
          end else begin
            st <= GAP;
          end
        end
        GAP: begin
          if (O) begin
            st        <= DONE;
            done      <= 1'b1;
            pass      <= 1'b0;
            err_early <= 1'b1;
          end else if (gcnt == CW'(1)) begin
            st   <= SECOND;
            gcnt <= '0;
            A    <= (mode_q == M_BA);
            B    <= (mode_q == M_AB);
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        SECOND: begin
          if (O) begin
            st        <= DONE;
            done      <= 1'b1;
            pass      <= 1'b0;
            err_early <= 1'b1;
          end else begin
            st <= WAIT_O;
`ifdef ABRO_DRV_TIMEOUT_EN
            wcnt <= '0;
`endif
          end
        end
        WAIT_O: begin
`ifdef ABRO_DRV_TIMEOUT_EN
          // O on the last allowed cycle still counts as a response
          if (O) begin
            st   <= DONE;
            done <= 1'b1;
            pass <= (mode_q != M_NEG);
            wcnt <= '0;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            st       <= DONE;
            done     <= 1'b1;
            pass     <= (mode_q == M_NEG);
            err_to_q <= (mode_q != M_NEG);
            wcnt     <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`else
          if (mode_q == M_NEG) begin
            st   <= DONE;
            done <= 1'b1;
            pass <= !O;
          end else if (O) begin
            st   <= DONE;
            done <= 1'b1;
            pass <= 1'b1;
          end
`endif
        end
        DONE: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/abro_driver.md
ABRO_DRIVER -- requirements
Module: abro_driver

Interface
REQ-001 Parameter CW, default 8: width of the gap and timeout counters.
REQ-002 Parameter TIMEOUT, default 16: cycles to wait for O before a timeout is declared; legal range 1 to 2^CW-1.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to run one sequence; sampled only in IDLE.
REQ-006 mode  in  2  sequence select: 00 A then B, 01 B then A, 10 A and B together, 11 A only (negative test).
REQ-007 gap  in  CW  idle cycles between the first and second pulse (modes 00/01).
REQ-008 A  out  1  registered stimulus to the ABRO responder.
REQ-009 B  out  1  registered stimulus to the ABRO responder.
REQ-010 O  in  1  response from the ABRO responder.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  single-cycle completion pulse.
REQ-013 pass  out  1  sequence verdict; valid from done, held until the next accepted start.
REQ-014 err_timeout  out  1  O missing in a positive mode; held like pass.
REQ-015 err_early  out  1  O seen before the sequence finished; held like pass.
REQ-016 state  out  3  current FSM state encoding: IDLE=0, FIRST=1, GAP=2, SECOND=3, WAIT_O=4, DONE=5.

Function
REQ-017 IDLE: start=1 latches mode and gap, clears pass/err_timeout/err_early, next state FIRST; start while busy SHALL be ignored.
REQ-018 FIRST (1 cycle): A=1 for mode 00/11, B=1 for mode 01, A=B=1 for mode 10; next state WAIT_O for modes 10/11, SECOND if gap=0, else GAP.
REQ-019 GAP: A=B=0 for exactly gap cycles (down-counter loaded with latched gap), then SECOND.
REQ-020 SECOND (1 cycle): drives the input not driven in FIRST (B for 00, A for 01); next state WAIT_O.
REQ-021 A and B SHALL be 0 in every state except FIRST and SECOND; each pulse is exactly one cycle wide.
REQ-022 O=1 in FIRST, GAP or SECOND: err_early=1, pass=0, next state DONE (sequence aborted, remaining pulses not driven).
REQ-023 WAIT_O: counter starts at 0 on entry and increments each cycle; O=1 -> DONE with pass=1 for modes 00/01/10, pass=0 for mode 11.
REQ-024 WAIT_O timeout: O still 0 after TIMEOUT cycles -> DONE; mode 11 gives pass=1; other modes give pass=0, err_timeout=1.
REQ-025 O=1 in the same cycle the timeout is reached SHALL count as O received.
REQ-026 DONE (1 cycle): done=1, then IDLE; earliest next start accepted the cycle after DONE.
REQ-027 Latency from accepted start to first pulse: 1 cycle; O is expected no earlier than 1 cycle after the last pulse (registered responder).
REQ-028 O in IDLE or DONE SHALL be ignored.

Reset
REQ-029 reset=1 asynchronously forces state IDLE; A, B, busy, done, pass, err_timeout, err_early all 0; counters 0.
REQ-030 reset mid-sequence SHALL abort without a done pulse; A/B drop in the same cycle reset asserts.

Configuration
REQ-031 Macro ABRO_DRV_TIMEOUT_EN defined: WAIT_O timeout per REQ-023..REQ-025.
REQ-032 Macro undefined: no timeout counter; WAIT_O exits only on O for modes 00/01/10 (may wait indefinitely); mode 11 stays in WAIT_O exactly 1 cycle, pass=!O; err_timeout tied 0.

Verification
REQ-033 mode=00, gap=3, responder correct: A pulse at cycle 1, B pulse at cycle 5, O at cycle 6 -> done at cycle 7, pass=1, errors 0.
REQ-034 mode=10, gap ignored: A=B=1 at cycle 1, O at cycle 2 -> pass=1; start held high during busy causes no second sequence.
REQ-035 (TIMEOUT_EN, TIMEOUT=16) mode=01, O held 0 -> done 16 cycles after entering WAIT_O, pass=0, err_timeout=1; mode=11, O held 0 -> pass=1.
REQ-036 mode=00, gap=5, O forced 1 during GAP -> next cycle DONE, err_early=1, pass=0, B never pulsed.
REQ-037 reset asserted during GAP -> A=B=busy=0 immediately, state=0, no done pulse; new start after release runs normally.
